sync_xfer_arbiter: RTL and testbench

- Round-robin arbiter and four-phase handshake sequencer that shares one clock-domain-crossing transfer channel among NREQ local requesters.
- Latches the winner's data word and drives the channel request. Synchronizes the far-domain acknowledge internally (2 flops).
- Reports per-requester completion or timeout.
- Sits between local producers and the bundled-data synchronizer channel on the synchronizer chip.

---
 rtl/sync_xfer_arbiter.sv | 126 ++++++++++++
 tb/tb_sync_xfer_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_xfer_arbiter.sv
// Round-robin arbiter plus four-phase handshake sequencer sharing one CDC transfer
// channel among NREQ requesters, with per-phase timeout and completion reporting.
module sync_xfer_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8,
  localparam int OW     = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*DW-1:0] data_i,
  output logic [NREQ-1:0]    done_o,
  output logic [NREQ-1:0]    err_o,
  output logic               chan_req_o,
  output logic [DW-1:0]      chan_data_o,
  input  logic               chan_ack_i,
  output logic               busy_o,
  output logic [OW-1:0]      owner_o
);

  typedef enum logic [2:0] {IDLE, REQ, REL, ERR, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            ack_m, ack_s;
  logic [TW-1:0]   timer;
  logic            timeout;
  logic [OW-1:0]   ptr, pick, ptr_inc;
  logic [OW:0]     scan_idx;
  logic            any_req;
  logic [DW-1:0]   pick_data;

  // Two-flop synchronizer for the far-domain acknowledge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= chan_ack_i;
      ack_s <= ack_m;
    end
  end

  // Scan upward from ptr with wrap; the first set request wins
  always_comb begin
    pick     = ptr;
    any_req  = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, ptr} + (OW+1)'(i);
      if (scan_idx >= (OW+1)'(NREQ)) scan_idx = scan_idx - (OW+1)'(NREQ);
      if (!any_req && req_i[scan_idx[OW-1:0]]) begin
        any_req = 1'b1;
        pick    = scan_idx[OW-1:0];
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == OW'(k)) pick_data = data_i[k*DW +: DW];
    end
  end

  assign ptr_inc = (owner_o == OW'(NREQ-1)) ? '0 : owner_o + 1'b1;
  assign timeout = (timer == TW'(TIMEOUT));
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Acknowledge edges take priority over a coincident timeout
  always_comb begin
    state_nxt = state;
    done_o    = '0;
    err_o     = '0;
    case (state)
      IDLE:  if (any_req) state_nxt = REQ;
      REQ: begin
        if (ack_s)        state_nxt = REL;
        else if (timeout) state_nxt = ERR;
      end
      REL: begin
        if (!ack_s) begin
          state_nxt       = IDLE;
          done_o[owner_o] = 1'b1;
        end else if (timeout) begin
          state_nxt = ERR;
        end
      end
      ERR: begin
        err_o[owner_o] = 1'b1;
        state_nxt      = DRAIN;
      end
      DRAIN: if (!ack_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan_req_o  <= 1'b0;
      chan_data_o <= '0;
      owner_o     <= '0;
      ptr         <= '0;
      timer       <= '0;
    end else begin
      chan_req_o <= (state_nxt == REQ);
      if (state == IDLE && any_req) begin
        owner_o     <= pick;
        chan_data_o <= pick_data;
      end
      if ((state == REL && !ack_s) || state == ERR) ptr <= ptr_inc;
      // Timer restarts on each phase entry and saturates at TIMEOUT
      if (state_nxt != state && (state_nxt == REQ || state_nxt == REL))
        timer <= '0;
      else if ((state == REQ || state == REL) && !timeout)
        timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_xfer_arbiter.sv
// Randomized scoreboard bench for sync_xfer_arbiter with a far-end acknowledge model.
module tb_sync_xfer_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 8;
  localparam int TIMEOUT = 15;
  localparam int TW = 8;
  localparam int M_RESP = 0;
  localparam int M_SILENT = 1;
  localparam int M_STUCK = 2;
  localparam int M_GLITCH = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_i = '0;
  logic [31:0] data_i = '0;
  logic [3:0]  done_o, err_o;
  logic        chan_req_o;
  logic [7:0]  chan_data_o;
  logic        chan_ack_i = 1'b0;
  logic        busy_o;
  logic [1:0]  owner_o;

  typedef struct {
    int         owner;
    logic [7:0] data;
    bit         is_err;
    int         req_len;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_pulse = 0;
  int         ptr_m = 0;
  int         mode = M_RESP;
  int         run_len = 0;
  int         last_len = 0;
  logic [7:0] words[4];
  time        t_start = 0;
  time        t_pulse = 0;
  logic       last_req = 1'b0;
  logic       req_d = 1'b0;

  sync_xfer_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .data_i(data_i),
    .done_o(done_o), .err_o(err_o), .chan_req_o(chan_req_o),
    .chan_data_o(chan_data_o), .chan_ack_i(chan_ack_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference arbitration: first set request scanning upward from ptr with wrap
  function automatic int pick_m(input logic [3:0] rq, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (p + i) % NREQ;
      if (rq[k[1:0]]) return k;
    end
    return 0;
  endfunction

  task automatic load_words();
    for (int i = 0; i < NREQ; i++) words[i] = 8'($urandom);
    data_i = {words[3], words[2], words[1], words[0]};
  endtask

  task automatic push_exp(input int w, input bit is_err, input int rlen);
    exp_t e;
    e.owner = w; e.data = words[w]; e.is_err = is_err; e.req_len = rlen;
    q.push_back(e);
    ptr_m = (w + 1) % NREQ;
  endtask

  task automatic wait_busy();
    for (int c = 0; c < 50 && !busy_o; c++) @(negedge clk);
    check("grant_seen", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_pulses(input int target);
    for (int c = 0; c < 300 && n_pulse < target; c++) @(negedge clk);
    check("pulse_seen", 32'(n_pulse >= target), 32'd1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 100 && busy_o; c++) @(negedge clk);
    check("back_to_idle", 32'(busy_o), 32'd0);
  endtask

  task automatic run_xfer(input logic [3:0] rq, input int fmode, input int hold,
                          input bit is_err, input int rlen);
    int target;
    @(negedge clk);
    push_exp(pick_m(rq, ptr_m), is_err, rlen);
    target  = n_pulse + 1;
    mode    = fmode;
    req_i   = rq;
    t_start = $time;
    wait_busy();
    repeat (hold) @(negedge clk);
    req_i = '0;
    wait_pulses(target);
    wait_idle();
  endtask

  // Far end: ack follows chan_req one cycle late, or misbehaves per mode
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        M_RESP:   chan_ack_i = req_d;
        M_SILENT: chan_ack_i = 1'b0;
        M_STUCK:  if (req_d) chan_ack_i = 1'b1;
        default: begin
          chan_ack_i = 1'b0;
          #2 chan_ack_i = 1'b1;
          #3 chan_ack_i = 1'b0;
        end
      endcase
      req_d = chan_req_o;
    end
  end

  // Monitor: pops the scoreboard on every done/err pulse
  initial begin
    exp_t       e;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (reset) begin
        run_len  = 0;
        last_req = 1'b0;
      end else begin
        if (chan_req_o) run_len++;
        else if (run_len > 0) begin
          last_len = run_len;
          run_len  = 0;
        end
        if (chan_req_o && !last_req && q.size() > 0)
          check("data_on_req", 32'(chan_data_o), 32'(q[0].data));
        last_req = chan_req_o;
        if (done_o != '0 || err_o != '0) begin
          n_pulse++;
          t_pulse = $time;
          if (q.size() == 0) begin
            check("unexpected_pulse", 32'({err_o, done_o}), 32'd0);
          end else begin
            e  = q.pop_front();
            oh = 4'(1 << e.owner);
            check("done_vec", 32'(done_o), e.is_err ? 32'd0 : 32'(oh));
            check("err_vec", 32'(err_o), e.is_err ? 32'(oh) : 32'd0);
            check("owner", 32'(owner_o), 32'(e.owner));
            check("data_hold", 32'(chan_data_o), 32'(e.data));
            if (e.req_len > 0) check("req_high_len", 32'(last_len), 32'(e.req_len));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 300000", $time);
    $fatal(1);
  end

  initial begin
    int         target;
    int         w;
    logic [3:0] rq;
    bit         drain_bad;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_chan_req", 32'(chan_req_o), 32'd0);
    check("rst_chan_data", 32'(chan_data_o), 32'd0);
    check("rst_pulses", 32'({err_o, done_o}), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_owner", 32'(owner_o), 32'd0);
    reset = 1'b0;
    ptr_m = 0;

    // Round robin with all requests held
    @(negedge clk);
    load_words();
    for (int i = 0; i < 5; i++) push_exp(pick_m(4'hF, ptr_m), 1'b0, -1);
    target = n_pulse + 5;
    mode   = M_RESP;
    req_i  = 4'hF;
    wait_pulses(target);
    req_i = '0;
    wait_idle();

    // Single requester with minimum latency
    load_words();
    words[0] = 8'hA5;
    data_i = {words[3], words[2], words[1], words[0]};
    run_xfer(4'b0001, M_RESP, 1, 1'b0, -1);
    check("min_latency", 32'((t_pulse - t_start) / 10), 32'd8);
    check("single_owner", 32'(owner_o), 32'd0);

    // Timeout in REQ, then confirm the pointer moved on
    load_words();
    run_xfer(4'($urandom_range(1, 15)), M_SILENT, 1, 1'b1, TIMEOUT + 1);
    run_xfer(4'hF, M_RESP, 1, 1'b0, -1);

    // Stuck ack in REL: error, hold in DRAIN, then re-grant once ack falls
    @(negedge clk);
    load_words();
    rq = 4'b1000;
    w  = pick_m(rq, ptr_m);
    push_exp(w, 1'b1, -1);
    push_exp(w, 1'b0, -1);
    target = n_pulse + 1;
    mode   = M_STUCK;
    req_i  = rq;
    wait_pulses(target);
    drain_bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (chan_req_o || !busy_o) drain_bad = 1'b1;
    end
    check("drain_hold", 32'(drain_bad), 32'd0);
    target = n_pulse + 1;
    mode   = M_RESP;
    for (int c = 0; c < 50 && !chan_req_o; c++) @(negedge clk);
    check("regrant_after_drain", 32'(chan_req_o), 32'd1);
    req_i = '0;
    wait_pulses(target);
    wait_idle();

    // Async reset while the channel request is up
    @(negedge clk);
    load_words();
    mode  = M_SILENT;
    req_i = 4'b0010;
    wait_busy();
    check("pre_rst_owner", 32'(owner_o), 32'd1);
    req_i = '0;
    @(negedge clk);
    check("pre_rst_req", 32'(chan_req_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_chan_req", 32'(chan_req_o), 32'd0);
    check("arst_owner", 32'(owner_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_pulses", 32'({err_o, done_o}), 32'd0);
    check("arst_chan_data", 32'(chan_data_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 0;
    run_xfer(4'b0100, M_RESP, 1, 1'b0, -1);

    // Sub-cycle ack glitches never reach the synchronizer output
    load_words();
    run_xfer(4'($urandom_range(1, 15)), M_GLITCH, 1, 1'b1, TIMEOUT + 1);

    // Random traffic with requests dropped shortly after grant
    for (int n = 0; n < 12; n++) begin
      load_words();
      run_xfer(4'($urandom_range(1, 15)), M_RESP, $urandom_range(1, 3), 1'b0, -1);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
